// File: rtl/cpu_datapath_pkg.sv
// Shared definitions for the teaching-CPU datapath: bus width, step encodings,
// register indices and flag bit positions.
package cpu_datapath_pkg;

   localparam int W = 16;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } step_e;

   localparam logic [2:0] R0 = 3'd0;
   localparam logic [2:0] R1 = 3'd1;
   localparam logic [2:0] R2 = 3'd2;
   localparam logic [2:0] R3 = 3'd3;
   localparam logic [2:0] R4 = 3'd4;
   localparam logic [2:0] R5 = 3'd5;
   localparam logic [2:0] R6 = 3'd6;
   localparam logic [2:0] R7 = 3'd7;

   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 0;

endpackage

// File: rtl/cpu_datapath_if.sv
// Control-strobe bundle between the control unit (master) and the datapath (slave).
// oFlags exists only when DATAPATH_FLAGS_EN is defined.
interface cpu_datapath_if #(parameter int W = cpu_datapath_pkg::W);

   // Strobes are plain per-cycle qualifiers: each one acts on the next rising
   // edge when high; there is no valid/ready handshake and no back-pressure.
   logic         iRun;
   logic [W-1:0] iDin;
   logic         iIr_en;
   logic         iDin_en;
   logic         iGout;
   logic [2:0]   iRout;
   logic [7:0]   iRin;
   logic         iAin;
   logic         iGin;
   logic         iSub;
   logic         iDone;
   logic         iClear;
   logic [1:0]   oState;
   logic [8:0]   oIr;
   logic [W-1:0] oBus;
`ifdef DATAPATH_FLAGS_EN
   logic [2:0]   oFlags;
`endif

   modport master (
      output iRun, iDin, iIr_en, iDin_en, iGout, iRout, iRin, iAin, iGin, iSub,
             iDone, iClear,
`ifdef DATAPATH_FLAGS_EN
      input  oFlags,
`endif
      input  oState, oIr, oBus
   );

   modport slave (
      input  iRun, iDin, iIr_en, iDin_en, iGout, iRout, iRin, iAin, iGin, iSub,
             iDone, iClear,
`ifdef DATAPATH_FLAGS_EN
      output oFlags,
`endif
      output oState, oIr, oBus
   );

endinterface

// File: rtl/cpu_datapath_step_counter.sv
// 2-bit instruction step counter; clear beats done beats run, wraps S3 -> S0.
module cpu_datapath_step_counter
   import cpu_datapath_pkg::*;
(
   input  logic  iClk,
   input  logic  iRst_n,
   input  logic  iRun,
   input  logic  iDone,
   input  logic  iClear,
   output step_e oState
);

   step_e state_q;

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state_q <= S0;
      end else if (iClear || iDone) begin
         state_q <= S0;
      end else if (iRun) begin
         state_q <= step_e'(state_q + 2'd1);
      end
   end

   assign oState = state_q;

endmodule

// File: rtl/cpu_datapath.sv
// Datapath of the 16-bit teaching CPU: R0-R7, IR, A, G, add/sub ALU, shared bus
// and step counter. Optional {N,Z,C} flags with DATAPATH_FLAGS_EN.
module cpu_datapath
   import cpu_datapath_pkg::*;
(
   input  logic           iClk,
   input  logic           iRst_n,
   cpu_datapath_if.slave  dp
);

   logic [W-1:0] r_q [8];
   logic [W-1:0] a_q;
   logic [W-1:0] g_q;
   logic [8:0]   ir_q;
   logic [W-1:0] bus;
   logic [W-1:0] operand;
   logic [W:0]   alu_full;
   logic [W-1:0] alu_res;
   step_e        state;

   // One source always owns the bus; external data wins, then G, then a register.
   always_comb begin
      bus = r_q[dp.iRout];
      if (dp.iDin_en) begin
         bus = dp.iDin;
      end else if (dp.iGout) begin
         bus = g_q;
      end
   end

   // Subtraction is A + ~bus + 1, so the top bit is carry-out / no-borrow.
   always_comb begin
      operand  = dp.iSub ? ~bus : bus;
      alu_full = {1'b0, a_q} + {1'b0, operand} + {{W{1'b0}}, dp.iSub};
      alu_res  = alu_full[W-1:0];
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         for (int k = 0; k < 8; k++) begin
            r_q[k] <= '0;
         end
         a_q  <= '0;
         g_q  <= '0;
         ir_q <= '0;
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (dp.iRin[k]) begin
               r_q[k] <= bus;
            end
         end
         if (dp.iAin) begin
            a_q <= bus;
         end
         if (dp.iGin) begin
            g_q <= alu_res;
         end
         if (dp.iIr_en) begin
            ir_q <= dp.iDin[8:0];
         end
      end
   end

`ifdef DATAPATH_FLAGS_EN
   logic [2:0] flags_q;

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         flags_q <= '0;
      end else if (dp.iGin) begin
         flags_q[FLAG_N] <= alu_res[W-1];
         flags_q[FLAG_Z] <= (alu_res == '0);
         flags_q[FLAG_C] <= alu_full[W];
      end
   end

   assign dp.oFlags = flags_q;
`endif

   cpu_datapath_step_counter u_step_counter (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iRun   (dp.iRun),
      .iDone  (dp.iDone),
      .iClear (dp.iClear),
      .oState (state)
   );

   assign dp.oState = state;
   assign dp.oIr    = ir_q;
   assign dp.oBus   = bus;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed-vector bench for cpu_datapath; registers are observed through oBus.
// Flag checks are compiled in only with DATAPATH_FLAGS_EN.
module tb_cpu_datapath;
   import cpu_datapath_pkg::*;

   logic iClk;
   logic iRst_n;
   int   checks = 0;
   int   errors = 0;

   cpu_datapath_if #(.W(W)) dp ();

   cpu_datapath dut (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .dp     (dp)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic idle();
      dp.iRun    = 1'b0;
      dp.iDin    = '0;
      dp.iIr_en  = 1'b0;
      dp.iDin_en = 1'b0;
      dp.iGout   = 1'b0;
      dp.iRout   = R0;
      dp.iRin    = 8'h00;
      dp.iAin    = 1'b0;
      dp.iGin    = 1'b0;
      dp.iSub    = 1'b0;
      dp.iDone   = 1'b0;
      dp.iClear  = 1'b0;
   endtask

   task automatic read_reg(input logic [2:0] idx, output logic [W-1:0] val);
      idle();
      dp.iRout = idx;
      #1;
      val = dp.oBus;
   endtask

   task automatic read_g(output logic [W-1:0] val);
      idle();
      dp.iGout = 1'b1;
      #1;
      val = dp.oBus;
      dp.iGout = 1'b0;
   endtask

   task automatic mvi(input logic [2:0] idx, input logic [W-1:0] val);
      idle();
      dp.iDin    = val;
      dp.iDin_en = 1'b1;
      dp.iRin    = 8'h01 << idx;
      tick();
      idle();
   endtask

   task automatic test_reset();
      logic [W-1:0] v;
      checks++;
      if (dp.oState !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d want 0", dp.oState);
      end
      checks++;
      if (dp.oIr !== 9'h000) begin
         errors++;
         $display("FAIL reset_ir: got %h want 000", dp.oIr);
      end
      checks++;
      if (dp.oBus !== '0) begin
         errors++;
         $display("FAIL reset_bus: got %h want 0000", dp.oBus);
      end
      for (int k = 0; k < 8; k++) begin
         read_reg(3'(k), v);
         checks++;
         if (v !== '0) begin
            errors++;
            $display("FAIL reset_r%0d: got %h want 0000", k, v);
         end
      end
      read_g(v);
      checks++;
      if (v !== '0) begin
         errors++;
         $display("FAIL reset_g: got %h want 0000", v);
      end
   endtask

   task automatic test_mvi();
      logic [W-1:0] v;
      idle();
      dp.iDin    = 16'h00AB;
      dp.iDin_en = 1'b1;
      dp.iIr_en  = 1'b1;
      dp.iRin    = 8'b0000_0100;
      #1;
      checks++;
      if (dp.oBus !== 16'h00AB) begin
         errors++;
         $display("FAIL mvi_bus: got %h want 00ab", dp.oBus);
      end
      tick();
      read_reg(R2, v);
      checks++;
      if (v !== 16'h00AB) begin
         errors++;
         $display("FAIL mvi_r2: got %h want 00ab", v);
      end
      checks++;
      if (dp.oIr !== 9'h0AB) begin
         errors++;
         $display("FAIL mvi_ir: got %h want 0ab", dp.oIr);
      end
   endtask

   task automatic test_add();
      logic [W-1:0] v;
      mvi(R1, 16'h0005);
      mvi(R2, 16'h0003);
      dp.iRout = R1;
      dp.iAin  = 1'b1;
      tick();
      idle();
      dp.iRout = R2;
      dp.iGin  = 1'b1;
      tick();
      idle();
      dp.iGout = 1'b1;
      dp.iRin  = 8'b0000_0010;
      #1;
      checks++;
      if (dp.oBus !== 16'h0008) begin
         errors++;
         $display("FAIL add_gout_bus: got %h want 0008", dp.oBus);
      end
      tick();
      read_reg(R1, v);
      checks++;
      if (v !== 16'h0008) begin
         errors++;
         $display("FAIL add_r1: got %h want 0008", v);
      end
`ifdef DATAPATH_FLAGS_EN
      checks++;
      if (dp.oFlags !== 3'b000) begin
         errors++;
         $display("FAIL add_flags: got %b want 000", dp.oFlags);
      end
`endif
      // mv R1,R1 in the same cycle as copying R1 into R4 must leave both at 8
      idle();
      dp.iRout = R1;
      dp.iRin  = 8'b0001_0010;
      tick();
      read_reg(R1, v);
      checks++;
      if (v !== 16'h0008) begin
         errors++;
         $display("FAIL mv_same_r1: got %h want 0008", v);
      end
      read_reg(R4, v);
      checks++;
      if (v !== 16'h0008) begin
         errors++;
         $display("FAIL mv_r4: got %h want 0008", v);
      end
   endtask

   task automatic test_sub_wrap();
      logic [W-1:0] v;
      idle();
      dp.iRout = R0;
      dp.iAin  = 1'b1;
      tick();
      idle();
      dp.iDin    = 16'h0001;
      dp.iDin_en = 1'b1;
      dp.iSub    = 1'b1;
      dp.iGin    = 1'b1;
      tick();
      read_g(v);
      checks++;
      if (v !== 16'hFFFF) begin
         errors++;
         $display("FAIL sub_wrap_g: got %h want ffff", v);
      end
`ifdef DATAPATH_FLAGS_EN
      checks++;
      if (dp.oFlags !== 3'b100) begin
         errors++;
         $display("FAIL sub_wrap_flags: got %b want 100", dp.oFlags);
      end
`endif
      idle();
      dp.iDin    = 16'h0042;
      dp.iDin_en = 1'b1;
      dp.iAin    = 1'b1;
      tick();
      idle();
      dp.iDin    = 16'h0042;
      dp.iDin_en = 1'b1;
      dp.iSub    = 1'b1;
      dp.iGin    = 1'b1;
      tick();
      read_g(v);
      checks++;
      if (v !== 16'h0000) begin
         errors++;
         $display("FAIL sub_equal_g: got %h want 0000", v);
      end
`ifdef DATAPATH_FLAGS_EN
      checks++;
      if (dp.oFlags !== 3'b011) begin
         errors++;
         $display("FAIL sub_equal_flags: got %b want 011", dp.oFlags);
      end
`endif
      // A = 0xFFFF plus 1 wraps to zero with carry out
      idle();
      dp.iDin    = 16'hFFFF;
      dp.iDin_en = 1'b1;
      dp.iAin    = 1'b1;
      tick();
      idle();
      dp.iDin    = 16'h0001;
      dp.iDin_en = 1'b1;
      dp.iGin    = 1'b1;
      tick();
      read_g(v);
      checks++;
      if (v !== 16'h0000) begin
         errors++;
         $display("FAIL add_wrap_g: got %h want 0000", v);
      end
`ifdef DATAPATH_FLAGS_EN
      checks++;
      if (dp.oFlags !== 3'b011) begin
         errors++;
         $display("FAIL add_wrap_flags: got %b want 011", dp.oFlags);
      end
`endif
   endtask

   task automatic test_step_counter();
      logic [1:0]   exp_seq [4];
      logic [W-1:0] v;
      exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
      idle();
      dp.iClear = 1'b1;
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         dp.iRun = 1'b1;
         tick();
         checks++;
         if (dp.oState !== exp_seq[i]) begin
            errors++;
            $display("FAIL step_run_%0d: got %0d want %0d", i, dp.oState, exp_seq[i]);
         end
      end
      tick();
      dp.iDone = 1'b1;
      tick();
      dp.iDone = 1'b0;
      checks++;
      if (dp.oState !== 2'd0) begin
         errors++;
         $display("FAIL step_done: got %0d want 0", dp.oState);
      end
      tick();
      tick();
      dp.iClear = 1'b1;
      tick();
      dp.iClear = 1'b0;
      checks++;
      if (dp.oState !== 2'd0) begin
         errors++;
         $display("FAIL step_clear: got %0d want 0", dp.oState);
      end
      tick();
      dp.iRun = 1'b0;
      tick();
      tick();
      checks++;
      if (dp.oState !== 2'd1) begin
         errors++;
         $display("FAIL step_hold: got %0d want 1", dp.oState);
      end
      // final-step write completes alongside done
      idle();
      dp.iDone   = 1'b1;
      dp.iDin    = 16'h5A5A;
      dp.iDin_en = 1'b1;
      dp.iRin    = 8'b0010_0000;
      tick();
      read_reg(R5, v);
      checks++;
      if (v !== 16'h5A5A || dp.oState !== 2'd0) begin
         errors++;
         $display("FAIL done_write: got r5=%h state=%0d want r5=5a5a state=0", v, dp.oState);
      end
   endtask

   task automatic test_bus_priority();
      idle();
      dp.iRout = R0;
      dp.iAin  = 1'b1;
      tick();
      idle();
      dp.iDin    = 16'h1111;
      dp.iDin_en = 1'b1;
      dp.iGin    = 1'b1;
      tick();
      idle();
      dp.iDin    = 16'h2222;
      dp.iDin_en = 1'b1;
      dp.iGout   = 1'b1;
      dp.iRout   = R2;
      #1;
      checks++;
      if (dp.oBus !== 16'h2222) begin
         errors++;
         $display("FAIL prio_din: got %h want 2222", dp.oBus);
      end
      dp.iDin_en = 1'b0;
      #1;
      checks++;
      if (dp.oBus !== 16'h1111) begin
         errors++;
         $display("FAIL prio_g: got %h want 1111", dp.oBus);
      end
      dp.iGout = 1'b0;
      #1;
      checks++;
      if (dp.oBus !== 16'h0003) begin
         errors++;
         $display("FAIL prio_reg: got %h want 0003", dp.oBus);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [W-1:0] v;
      idle();
      dp.iClear = 1'b1;
      tick();
      idle();
      dp.iRun    = 1'b1;
      dp.iDin    = 16'h1234;
      dp.iDin_en = 1'b1;
      dp.iRin    = 8'b0000_1000;
      dp.iGin    = 1'b1;
      tick();
      idle();
      dp.iRun = 1'b1;
      tick();
      read_reg(R3, v);
      checks++;
      if (dp.oState !== 2'd2 || v !== 16'h1234) begin
         errors++;
         $display("FAIL pre_reset: got state=%0d r3=%h want state=2 r3=1234", dp.oState, v);
      end
      idle();
      iRst_n     = 1'b0;
      dp.iRun    = 1'b1;
      dp.iDin    = 16'h01FF;
      dp.iDin_en = 1'b1;
      dp.iIr_en  = 1'b1;
      dp.iRin    = 8'hFF;
      dp.iGin    = 1'b1;
      tick();
      iRst_n = 1'b1;
      idle();
      #1;
      checks++;
      if (dp.oState !== 2'd0) begin
         errors++;
         $display("FAIL midrst_state: got %0d want 0", dp.oState);
      end
      checks++;
      if (dp.oIr !== 9'h000) begin
         errors++;
         $display("FAIL midrst_ir: got %h want 000", dp.oIr);
      end
      read_reg(R3, v);
      checks++;
      if (v !== '0) begin
         errors++;
         $display("FAIL midrst_r3: got %h want 0000", v);
      end
      read_g(v);
      checks++;
      if (v !== '0) begin
         errors++;
         $display("FAIL midrst_g: got %h want 0000", v);
      end
`ifdef DATAPATH_FLAGS_EN
      checks++;
      if (dp.oFlags !== 3'b000) begin
         errors++;
         $display("FAIL midrst_flags: got %b want 000", dp.oFlags);
      end
`endif
   endtask

   initial begin
      idle();
      iRst_n = 1'b0;
      tick();
      tick();
      iRst_n = 1'b1;
      test_reset();
      test_mvi();
      test_add();
      test_sub_wrap();
      test_step_counter();
      test_bus_priority();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
